// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mm_pkg
// Brief    : Shared FP16 constants and the output-drain FSM state encoding
//            used by the matrix-multiply output normaliser.
// Revision : 1.0 - initial release
// ============================================================================
package mm_pkg;

  // FP16 field geometry and special encodings
  localparam int          FP16_EXP_W   = 5;
  localparam int          FP16_MANT_W  = 10;
  localparam int          FP16_BIAS    = 15;
  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;

  // Drain sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage : mm_pkg
`default_nettype wire

// File: rtl/fx2fp16.sv
`default_nettype none
// ============================================================================
// Module   : fx2fp16
// Brief    : Combinational conversion of a two's complement fixed-point
//            accumulator with a shared exponent into IEEE FP16.
//            Round to nearest even; overflow saturates to infinity,
//            underflow flushes to signed zero (no subnormals).
// Revision : 1.0 - initial release
// ============================================================================
module fx2fp16
  import mm_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int EXP_BIAS  = 15,
  parameter int FRAC_BITS = 10
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic [FP16_EXP_W-1:0] exp_in,
  output logic [15:0]           fp16
);

  // Extended vector: magnitude followed by room for mantissa + guard bits,
  // so narrow accumulators still zero-pad the mantissa naturally.
  localparam int EXT_W   = ACC_WIDTH + FP16_MANT_W + 1;
  // Constant part of the biased exponent: +15 - EXP_BIAS - FRAC_BITS
  localparam int EXP_OFF = FP16_BIAS - EXP_BIAS - FRAC_BITS;

  logic                   sign;
  logic [ACC_WIDTH-1:0]   mag;
  logic [15:0]            lead_pos;
  logic [EXT_W-1:0]       norm;
  logic [FP16_MANT_W-1:0] mant;
  logic                   guard;
  logic                   sticky;
  logic                   round_up;
  logic [FP16_MANT_W:0]   mant_rnd;
  logic signed [15:0]     exp_b;

  // Normalise, round and pack; specials override the packed result last
  always_comb begin
    sign     = acc[ACC_WIDTH-1];
    // Unsigned magnitude: the most-negative input maps to 2^(W-1) exactly
    mag      = sign ? (~acc + 1'b1) : acc;
    lead_pos = '0;
    for (int i = 0; i < ACC_WIDTH; i++) begin
      if (mag[i]) lead_pos = 16'(i);
    end
    // Shift so the leading one sits at the top bit of the extended vector
    norm     = {mag, {(FP16_MANT_W + 1){1'b0}}} << (16'(ACC_WIDTH - 1) - lead_pos);
    mant     = norm[EXT_W-2 -: FP16_MANT_W];
    guard    = norm[EXT_W-2-FP16_MANT_W];
    sticky   = |norm[EXT_W-3-FP16_MANT_W:0];
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {{FP16_MANT_W{1'b0}}, round_up};
    exp_b    = $signed(lead_pos) + $signed({11'b0, exp_in}) + 16'(EXP_OFF);
    // Mantissa overflow from rounding bumps the exponent (mantissa wraps to 0)
    if (mant_rnd[FP16_MANT_W]) exp_b = exp_b + 16'sd1;

    fp16 = {sign, exp_b[4:0], mant_rnd[FP16_MANT_W-1:0]};
    if (mag == '0) begin
      fp16 = 16'h0000;
    end else if (exp_b >= 16'sd31) begin
      fp16 = sign ? FP16_NEG_INF : FP16_POS_INF;
    end else if (exp_b <= 16'sd0) begin
      fp16 = {sign, 15'b0};
    end
  end

endmodule : fx2fp16
`default_nettype wire

// File: rtl/mm_out_norm.sv
`default_nettype none
// ============================================================================
// Module   : mm_out_norm
// Brief    : Snapshots an N x N tile of PE accumulators on the rising edge of
//            done and drains them one at a time as FP16 over a valid/ready
//            stream, sharing a single fx2fp16 converter across elements.
// Revision : 1.0 - initial release
// ============================================================================
module mm_out_norm
  import mm_pkg::*;
#(
  parameter int N         = 2,
  parameter int ACC_WIDTH = 32,
  parameter int EXP_BIAS  = 15,
  parameter int FRAC_BITS = 10,
  localparam int NUM      = N * N,
  localparam int IDX_W    = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           done,
  input  logic [NUM*ACC_WIDTH-1:0]       acc_in,
  input  logic [NUM*FP16_EXP_W-1:0]      exp_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [15:0]                    out_data,
  output logic [IDX_W-1:0]               out_idx,
  output logic                           out_last,
  output logic                           busy,
  output logic                           overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

  state_e                                state_q, state_d;
  logic                                  done_q, done_d;
  logic [NUM-1:0][ACC_WIDTH-1:0]         acc_cap_q, acc_cap_d;
  logic [NUM-1:0][FP16_EXP_W-1:0]        exp_cap_q, exp_cap_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic                                  out_valid_q, out_valid_d;
  logic [15:0]                           out_data_q, out_data_d;
  logic [IDX_W-1:0]                      out_idx_q, out_idx_d;
  logic                                  out_last_q, out_last_d;
  logic                                  busy_q, busy_d;
  logic                                  overrun_q, overrun_d;
  logic                                  done_edge;
  logic [15:0]                           conv_fp16;

  assign done_edge = done & ~done_q;

  // One converter, steered by the current drain index
  fx2fp16 #(
    .ACC_WIDTH (ACC_WIDTH),
    .EXP_BIAS  (EXP_BIAS),
    .FRAC_BITS (FRAC_BITS)
  ) u_conv (
    .acc    (acc_cap_q[idx_q]),
    .exp_in (exp_cap_q[idx_q]),
    .fp16   (conv_fp16)
  );

  // Next-state and output-register logic for the capture/convert/hold drain
  always_comb begin
    state_d     = state_q;
    done_d      = done;
    acc_cap_d   = acc_cap_q;
    exp_cap_d   = exp_cap_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    // A new tile arriving before the current one finishes is only flagged;
    // busy is still high in the final-transfer cycle, so that edge is lost too
    overrun_d   = overrun_q | (done_edge & busy_q);

    unique case (state_q)
      ST_IDLE: begin
        if (done_edge) begin
          acc_cap_d = acc_in;
          exp_cap_d = exp_in;
          idx_d     = '0;
          busy_d    = 1'b1;
          state_d   = ST_CONV;
        end
      end
      ST_CONV: begin
        out_data_d  = conv_fp16;
        out_idx_d   = idx_q;
        out_last_d  = (idx_q == LAST_IDX);
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_CONV;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      acc_cap_q   <= '0;
      exp_cap_q   <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      acc_cap_q   <= acc_cap_d;
      exp_cap_q   <= exp_cap_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule : mm_out_norm
`default_nettype wire

// File: tb/tb_mm_out_norm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mm_out_norm
// Brief    : Self-checking bench for mm_out_norm: directed tiles plus random
//            tiles scored against a real-arithmetic FP16 reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mm_out_norm;

  localparam int N         = 2;
  localparam int NUM       = N * N;
  localparam int AW        = 32;
  localparam int EXP_BIAS  = 15;
  localparam int FRAC_BITS = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic                done;
  logic [NUM*AW-1:0]   acc_in;
  logic [NUM*5-1:0]    exp_in;
  logic                out_valid;
  logic                out_ready;
  logic [15:0]         out_data;
  logic [1:0]          out_idx;
  logic                out_last;
  logic                busy;
  logic                overrun;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] t_acc [NUM];
  logic [4:0]  t_exp [NUM];
  logic [15:0] exp_q [NUM];

  mm_out_norm #(
    .N         (N),
    .ACC_WIDTH (AW),
    .EXP_BIAS  (EXP_BIAS),
    .FRAC_BITS (FRAC_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .acc_in    (acc_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact value acc * 2^(exp-25) in double precision, then
  // normalised to [1,2) and rounded to 10 fraction bits, ties to even.
  function automatic logic [15:0] ref_fp16(input logic [31:0] a, input logic [4:0] e);
    longint v;
    longint fl;
    real    m;
    real    frac;
    real    rem;
    int     ex;
    int     eb;
    logic   s;
    s = a[31];
    v = longint'($signed(a));
    if (v < 0) v = -v;
    if (v == 0) return 16'h0000;
    m  = real'(v);
    ex = int'(e) - EXP_BIAS - FRAC_BITS;
    while (m >= 2.0) begin m = m / 2.0; ex++; end
    while (m < 1.0)  begin m = m * 2.0; ex--; end
    frac = (m - 1.0) * 1024.0;
    fl   = longint'($floor(frac));
    rem  = frac - real'(fl);
    if (rem > 0.5 || (rem == 0.5 && fl[0])) fl++;
    if (fl == 1024) begin fl = 0; ex++; end
    eb = ex + 15;
    if (eb >= 31) return s ? 16'hFC00 : 16'h7C00;
    if (eb <= 0)  return {s, 15'b0};
    return {s, 5'(eb), 10'(fl)};
  endfunction

  task automatic apply_tile();
    for (int i = 0; i < NUM; i++) begin
      acc_in[i*AW +: AW] = t_acc[i];
      exp_in[i*5 +: 5]   = t_exp[i];
    end
  endtask

  task automatic model_fill();
    for (int i = 0; i < NUM; i++) exp_q[i] = ref_fp16(t_acc[i], t_exp[i]);
  endtask

  task automatic random_tile();
    for (int i = 0; i < NUM; i++) begin
      case ($urandom_range(0, 3))
        0:       t_acc[i] = $urandom;
        1:       t_acc[i] = 32'($urandom_range(0, 4095));
        2:       t_acc[i] = -32'($urandom_range(0, 4095));
        default: t_acc[i] = $urandom >> $urandom_range(0, 31);
      endcase
      t_exp[i] = 5'($urandom_range(0, 31));
    end
  endtask

  // Raise done, confirm capture and the two-cycle first-output latency
  task automatic start_tile(input bit hold_done);
    done = 1'b1;
    tick();
    check("lat_early_valid", 32'(out_valid), 32'd0);
    check("busy_on_capture", 32'(busy), 32'd1);
    if (!hold_done) done = 1'b0;
    tick();
    check("lat_first_valid", 32'(out_valid), 32'd1);
  endtask

  // Drain one tile against exp_q. ready_mode: 0 always, 1 random,
  // 2 stall 5 cycles on idx 1. inject_idx >= 0 pulses done while that index
  // is presented.
  task automatic drain(input int ready_mode, input int inject_idx, output int ntx);
    int          k = 0;
    int          cyc = 0;
    int          stall = 0;
    bit          fired = 1'b0;
    bit          stalled_once = 1'b0;
    bit          pv_hold = 1'b0;
    logic [15:0] pv_data = '0;
    logic [1:0]  pv_idx = '0;
    while (k < NUM && cyc < 200) begin
      if (pv_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(pv_data));
        check("hold_idx", 32'(out_idx), 32'(pv_idx));
      end
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = 1'b1;
          if (out_valid && out_idx == 2'd1 && !stalled_once) begin
            if (stall < 5) begin out_ready = 1'b0; stall++; end
            else stalled_once = 1'b1;
          end
        end
      endcase
      if (inject_idx >= 0) begin
        if (out_valid && int'(out_idx) == inject_idx && !fired) begin
          done  = 1'b1;
          fired = 1'b1;
        end else begin
          done = 1'b0;
        end
      end
      pv_hold = out_valid && !out_ready;
      pv_data = out_data;
      pv_idx  = out_idx;
      if (out_valid && out_ready) begin
        check("data", 32'(out_data), 32'(exp_q[k]));
        check("idx", 32'(out_idx), 32'(k));
        check("last", 32'(out_last), 32'(k == NUM - 1));
        k++;
      end
      tick();
      cyc++;
    end
    if (k < NUM) check("drain_timeout", 32'(k), 32'(NUM));
    if (ready_mode == 2) check("stall_len", 32'(stall), 32'd5);
    ntx = k;
    check("busy_after_tile", 32'(busy), 32'd0);
    check("valid_after_tile", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int ntx;
    int seen;
    rst       = 1'b1;
    done      = 1'b0;
    out_ready = 1'b0;
    acc_in    = '0;
    exp_in    = '0;
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick();

    // Basic tile: one, minus one, zero, overflow
    t_acc = '{32'h0000_0400, 32'hFFFF_FC00, 32'h0000_0000, 32'h7FFF_FFFF};
    t_exp = '{5'd15, 5'd15, 5'd15, 5'd15};
    exp_q = '{16'h3C00, 16'hBC00, 16'h0000, 16'h7C00};
    apply_tile();
    start_tile(1'b0);
    drain(0, -1, ntx);
    check("basic_overrun", 32'(overrun), 32'd0);

    // Rounding cases incl. carry into exponent
    t_acc = '{32'h0000_0801, 32'h0000_0803, 32'h0000_0FFF, 32'h0000_07FF};
    exp_q = '{16'h4000, 16'h4002, 16'h4400, 16'h3FFF};
    apply_tile();
    start_tile(1'b0);
    drain(1, -1, ntx);

    // Backpressure on idx 1
    random_tile();
    model_fill();
    apply_tile();
    start_tile(1'b0);
    drain(2, -1, ntx);

    // Overrun: second done edge while idx 2 is presented
    random_tile();
    model_fill();
    apply_tile();
    start_tile(1'b0);
    drain(0, 2, ntx);
    check("overrun_set", 32'(overrun), 32'd1);
    done = 1'b0;
    tick();
    random_tile();
    model_fill();
    apply_tile();
    start_tile(1'b0);
    drain(1, -1, ntx);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Asynchronous reset while idx 1 is presented
    random_tile();
    apply_tile();
    start_tile(1'b0);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      if (out_valid && out_idx == 2'd1) seen = 1;
      else tick();
    end
    check("reach_idx1", 32'(seen), 32'd1);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    check("arst_idx", 32'(out_idx), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    tick();
    #2 rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) seen++;
    end
    check("post_rst_quiet", 32'(seen), 32'd0);

    // Flush to zero with done held high for 10 cycles
    t_acc = '{32'h1, 32'h1, 32'h1, 32'h1};
    t_exp = '{5'd0, 5'd0, 5'd0, 5'd0};
    exp_q = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    apply_tile();
    start_tile(1'b1);
    drain(0, -1, ntx);
    check("held_done_ntx", 32'(ntx), 32'(NUM));
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid) seen++;
    end
    done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) seen++;
    end
    check("held_done_single_tile", 32'(seen), 32'd0);
    check("held_done_busy", 32'(busy), 32'd0);

    // Random tiles with random backpressure
    for (int t = 0; t < 20; t++) begin
      random_tile();
      model_fill();
      apply_tile();
      start_tile(1'b0);
      drain(1, -1, ntx);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mm_out_norm
`default_nettype wire
